// File: rtl/rf_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_pkg
// Brief    : Shared types for the register-file writeback port.
// Revision : 1.0
// ============================================================================
package rf_wb_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } rf_wr_t;

endpackage
`default_nettype wire

// File: rtl/rf_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_fifo
// Brief    : In-order synchronous FIFO of rf_wr_t with count/full/empty.
// Revision : 1.0
// ============================================================================
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  rf_wr_t      i_wdata,
  input  logic        i_pop,
  output rf_wr_t      o_rdata,
  output logic [AW:0] o_count,
  output logic        o_full,
  output logic        o_empty
);

  rf_wr_t        r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/rf_writeback_port.sv
`default_nettype none
// ============================================================================
// Module   : rf_writeback_port
// Brief    : Single RF write port arbiter (ALU > queued load > bypass load)
//            with load-destination scoreboard. Optional macro WB_STALL_CNT_EN
//            adds o_stall_cnt.
// Revision : 1.0
// ============================================================================
module rf_writeback_port
  import rf_wb_pkg::*;
#(
  parameter int XLEN   = rf_wb_pkg::XLEN,
  parameter int QDEPTH = 4
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_alu_valid,
  input  logic [4:0]      i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic            i_lsu_issue,
  input  logic [4:0]      i_lsu_issue_rd,
  input  logic            i_lsu_rsp_valid,
  output logic            o_lsu_rsp_ready,
  input  logic [4:0]      i_lsu_rsp_rd,
  input  logic [XLEN-1:0] i_lsu_rsp_data,
  output logic            o_rf_load,
  output logic [4:0]      o_rf_dest,
  output logic [XLEN-1:0] o_rf_in,
`ifdef WB_STALL_CNT_EN
  output logic [31:0]     o_stall_cnt,
`endif
  output logic [NREG-1:0] o_pending
);

  localparam int QCW = $clog2(QDEPTH) + 1;

  rf_wr_t          w_head;
  rf_wr_t          w_rsp;
  rf_wr_t          w_win;
  logic [QCW-1:0]  w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_alu_win;
  logic            w_accept;
  logic            w_rsp_keep;
  logic            w_pop;
  logic            w_bypass;
  logic            w_push;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_set;

  logic            r_load;
  logic [4:0]      r_dest;
  logic [XLEN-1:0] r_data;
  logic [NREG-1:0] r_pending;

  assign o_lsu_rsp_ready = (w_count != QCW'(QDEPTH));
  assign w_accept        = i_lsu_rsp_valid && o_lsu_rsp_ready;
  // Responses to x0 are consumed here and never reach the queue.
  assign w_rsp_keep      = w_accept && (i_lsu_rsp_rd != 5'd0);
  assign w_alu_win       = i_alu_valid && (i_alu_rd != 5'd0);
  assign w_rsp           = '{valid: 1'b1, rd: i_lsu_rsp_rd, data: i_lsu_rsp_data};

  always_comb begin
    w_win    = '0;
    w_pop    = 1'b0;
    w_bypass = 1'b0;
    if (w_alu_win) begin
      w_win = '{valid: 1'b1, rd: i_alu_rd, data: i_alu_data};
    end else if (!w_empty) begin
      w_win = w_head;
      w_pop = 1'b1;
    end else if (w_rsp_keep) begin
      w_win    = w_rsp;
      w_bypass = 1'b1;
    end
  end

  assign w_push = w_rsp_keep && !w_bypass && !w_full;

  rf_wb_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_rsp),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load <= 1'b0;
      r_dest <= '0;
      r_data <= '0;
    end else begin
      r_load <= w_win.valid;
      if (w_win.valid) begin
        r_dest <= w_win.rd;
        r_data <= w_win.data;
      end
    end
  end

  // Set is applied after clear so a same-cycle re-issue keeps the bit high.
  assign w_clr = (w_pop || w_bypass) ? (NREG'(1) << w_win.rd) : '0;
  assign w_set = i_lsu_issue ? (NREG'(1) << i_lsu_issue_rd) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= ((r_pending & ~w_clr) | w_set) & ~NREG'(1);
    end
  end

  assign o_rf_load = r_load;
  assign o_rf_dest = r_dest;
  assign o_rf_in   = r_data;
  assign o_pending = r_pending;

`ifdef WB_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_alu_win && !w_empty && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_writeback_port
// Brief    : Directed self-checking bench for rf_writeback_port.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_rf_writeback_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_alu_valid = 1'b0;
  logic [4:0]  i_alu_rd = '0;
  logic [31:0] i_alu_data = '0;
  logic        i_lsu_issue = 1'b0;
  logic [4:0]  i_lsu_issue_rd = '0;
  logic        i_lsu_rsp_valid = 1'b0;
  logic        o_lsu_rsp_ready;
  logic [4:0]  i_lsu_rsp_rd = '0;
  logic [31:0] i_lsu_rsp_data = '0;
  logic        o_rf_load;
  logic [4:0]  o_rf_dest;
  logic [31:0] o_rf_in;
  logic [31:0] o_pending;
`ifdef WB_STALL_CNT_EN
  logic [31:0] o_stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  rf_writeback_port #(.XLEN(32), .QDEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_alu_valid     (i_alu_valid),
    .i_alu_rd        (i_alu_rd),
    .i_alu_data      (i_alu_data),
    .i_lsu_issue     (i_lsu_issue),
    .i_lsu_issue_rd  (i_lsu_issue_rd),
    .i_lsu_rsp_valid (i_lsu_rsp_valid),
    .o_lsu_rsp_ready (o_lsu_rsp_ready),
    .i_lsu_rsp_rd    (i_lsu_rsp_rd),
    .i_lsu_rsp_data  (i_lsu_rsp_data),
    .o_rf_load       (o_rf_load),
    .o_rf_dest       (o_rf_dest),
    .o_rf_in         (o_rf_in),
`ifdef WB_STALL_CNT_EN
    .o_stall_cnt     (o_stall_cnt),
`endif
    .o_pending       (o_pending)
  );

  always #5 clk = ~clk;

  // A re-issue to a pending rd is only legal when that rd is written back at the same edge.
  logic       a_v;
  logic [4:0] a_rd;
  always @(posedge clk) begin
    a_v  = !rst && i_lsu_issue && o_pending[i_lsu_issue_rd];
    a_rd = i_lsu_issue_rd;
    #1;
    if (a_v) assert (o_rf_load && o_rf_dest == a_rd)
      else $error("issue to pending rd %0d", a_rd);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    i_alu_valid = 1'b0; i_alu_rd = '0; i_alu_data = '0;
    i_lsu_issue = 1'b0; i_lsu_issue_rd = '0;
    i_lsu_rsp_valid = 1'b0; i_lsu_rsp_rd = '0; i_lsu_rsp_data = '0;
  endtask

  task automatic do_reset;
    idle();
    @(posedge clk);
    #1 rst = 1'b1;
    #4 rst = 1'b0;
    step();
  endtask

  task automatic test_reset;
    do_reset();
    n_tests++; if (o_rf_load !== 1'b0) begin n_fail++; $display("FAIL reset_load got %0b want 0", o_rf_load); end
    n_tests++; if (o_rf_dest !== 5'd0) begin n_fail++; $display("FAIL reset_dest got %0d want 0", o_rf_dest); end
    n_tests++; if (o_rf_in !== 32'd0) begin n_fail++; $display("FAIL reset_in got %0h want 0", o_rf_in); end
    n_tests++; if (o_pending !== 32'd0) begin n_fail++; $display("FAIL reset_pending got %0h want 0", o_pending); end
    n_tests++; if (o_lsu_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", o_lsu_rsp_ready); end
  endtask

  task automatic test_bypass;
    do_reset();
    i_lsu_issue = 1'b1; i_lsu_issue_rd = 5'd5;
    step();
    idle();
    n_tests++; if (o_pending !== 32'h20) begin n_fail++; $display("FAIL byp_pending_set got %0h want 20", o_pending); end
    i_lsu_rsp_valid = 1'b1; i_lsu_rsp_rd = 5'd5; i_lsu_rsp_data = 32'hDEADBEEF;
    step();
    idle();
    n_tests++; if (o_rf_load !== 1'b1) begin n_fail++; $display("FAIL byp_load got %0b want 1", o_rf_load); end
    n_tests++; if (o_rf_dest !== 5'd5) begin n_fail++; $display("FAIL byp_dest got %0d want 5", o_rf_dest); end
    n_tests++; if (o_rf_in !== 32'hDEADBEEF) begin n_fail++; $display("FAIL byp_in got %0h want deadbeef", o_rf_in); end
    n_tests++; if (o_pending !== 32'h0) begin n_fail++; $display("FAIL byp_pending_clr got %0h want 0", o_pending); end
    step();
    n_tests++; if (o_rf_load !== 1'b0) begin n_fail++; $display("FAIL byp_noload got %0b want 0", o_rf_load); end
    n_tests++; if (o_rf_dest !== 5'd5 || o_rf_in !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL byp_hold got %0d/%0h want 5/deadbeef", o_rf_dest, o_rf_in); end
  endtask

  task automatic test_alu_priority;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      i_lsu_issue = 1'b1; i_lsu_issue_rd = 5'(10 + k);
      step();
    end
    idle();
    n_tests++; if (o_pending !== 32'h3C00) begin n_fail++; $display("FAIL pri_pending got %0h want 3c00", o_pending); end
    for (int k = 0; k < 6; k++) begin
      idle();
      i_alu_valid = 1'b1; i_alu_rd = 5'(k + 1); i_alu_data = 32'h100 + 32'(k);
      if (k < 4) begin
        i_lsu_rsp_valid = 1'b1; i_lsu_rsp_rd = 5'(10 + k); i_lsu_rsp_data = 32'hA000 + 32'(k);
      end else begin
        n_tests++; if (o_lsu_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL pri_ready_full k=%0d got %0b want 0", k, o_lsu_rsp_ready); end
      end
      step();
      n_tests++;
      if (o_rf_load !== 1'b1 || o_rf_dest !== 5'(k + 1) || o_rf_in !== 32'h100 + 32'(k)) begin
        n_fail++; $display("FAIL pri_alu k=%0d got %0b/%0d/%0h want 1/%0d/%0h", k, o_rf_load, o_rf_dest, o_rf_in, k + 1, 32'h100 + 32'(k));
      end
    end
    idle();
    for (int j = 0; j < 4; j++) begin
      step();
      n_tests++;
      if (o_rf_load !== 1'b1 || o_rf_dest !== 5'(10 + j) || o_rf_in !== 32'hA000 + 32'(j)) begin
        n_fail++; $display("FAIL pri_load j=%0d got %0b/%0d/%0h want 1/%0d/%0h", j, o_rf_load, o_rf_dest, o_rf_in, 10 + j, 32'hA000 + 32'(j));
      end
    end
    n_tests++; if (o_pending !== 32'h0) begin n_fail++; $display("FAIL pri_pending_clr got %0h want 0", o_pending); end
    step();
    n_tests++; if (o_rf_load !== 1'b0) begin n_fail++; $display("FAIL pri_drained got %0b want 0", o_rf_load); end
`ifdef WB_STALL_CNT_EN
    n_tests++; if (o_stall_cnt !== 32'd5) begin n_fail++; $display("FAIL pri_stall_cnt got %0d want 5", o_stall_cnt); end
`endif
  endtask

  task automatic test_x0;
    do_reset();
    i_alu_valid = 1'b1; i_alu_rd = 5'd0; i_alu_data = 32'h5555;
    i_lsu_rsp_valid = 1'b1; i_lsu_rsp_rd = 5'd7; i_lsu_rsp_data = 32'h77;
    step();
    idle();
    n_tests++; if (o_rf_load !== 1'b1 || o_rf_dest !== 5'd7 || o_rf_in !== 32'h77) begin
      n_fail++; $display("FAIL x0_alu got %0b/%0d/%0h want 1/7/77", o_rf_load, o_rf_dest, o_rf_in); end
    step();
    n_tests++; if (o_rf_load !== 1'b0) begin n_fail++; $display("FAIL x0_single got %0b want 0", o_rf_load); end
    i_lsu_rsp_valid = 1'b1; i_lsu_rsp_rd = 5'd0; i_lsu_rsp_data = 32'h1234;
    step();
    idle();
    n_tests++; if (o_rf_load !== 1'b0) begin n_fail++; $display("FAIL x0_rsp got %0b want 0", o_rf_load); end
    step();
    n_tests++; if (o_rf_load !== 1'b0) begin n_fail++; $display("FAIL x0_noq got %0b want 0", o_rf_load); end
    n_tests++; if (o_rf_dest !== 5'd7 || o_rf_in !== 32'h77) begin
      n_fail++; $display("FAIL x0_hold got %0d/%0h want 7/77", o_rf_dest, o_rf_in); end
  endtask

  task automatic test_collision;
    do_reset();
    i_lsu_issue = 1'b1; i_lsu_issue_rd = 5'd9;
    step();
    idle();
    n_tests++; if (o_pending !== 32'h200) begin n_fail++; $display("FAIL col_set got %0h want 200", o_pending); end
    i_lsu_issue = 1'b1; i_lsu_issue_rd = 5'd9;
    i_lsu_rsp_valid = 1'b1; i_lsu_rsp_rd = 5'd9; i_lsu_rsp_data = 32'h99;
    step();
    idle();
    n_tests++; if (o_rf_load !== 1'b1 || o_rf_dest !== 5'd9 || o_rf_in !== 32'h99) begin
      n_fail++; $display("FAIL col_write got %0b/%0d/%0h want 1/9/99", o_rf_load, o_rf_dest, o_rf_in); end
    n_tests++; if (o_pending !== 32'h200) begin n_fail++; $display("FAIL col_keep got %0h want 200", o_pending); end
    i_lsu_rsp_valid = 1'b1; i_lsu_rsp_rd = 5'd9; i_lsu_rsp_data = 32'h9A;
    step();
    idle();
    n_tests++; if (o_pending !== 32'h0) begin n_fail++; $display("FAIL col_clr got %0h want 0", o_pending); end
  endtask

  task automatic test_wrap;
    logic [36:0] mq[$];
    logic [36:0] e;
    int sent = 0, seen = 0, cyc = 0;
    logic ev, acc, exp_ready;
    logic [4:0] erd;
    logic [31:0] edata;
    do_reset();
    while ((sent < 20 || mq.size() != 0) && cyc < 100) begin
      idle();
      i_alu_valid = (cyc % 2 == 0); i_alu_rd = 5'd1; i_alu_data = 32'hA0000000 + 32'(cyc);
      i_lsu_rsp_valid = (sent < 20);
      i_lsu_rsp_rd = 5'(8 + sent); i_lsu_rsp_data = 32'hC0000000 + 32'(sent) * 32'h1111;
      exp_ready = (mq.size() < 4);
      n_tests++; if (o_lsu_rsp_ready !== exp_ready) begin
        n_fail++; $display("FAIL wrap_ready cyc=%0d got %0b want %0b", cyc, o_lsu_rsp_ready, exp_ready); end
      acc = i_lsu_rsp_valid && exp_ready;
      ev = 1'b1; erd = '0; edata = '0;
      if (i_alu_valid) begin
        erd = i_alu_rd; edata = i_alu_data;
        if (acc) mq.push_back({i_lsu_rsp_rd, i_lsu_rsp_data});
      end else if (mq.size() != 0) begin
        e = mq.pop_front(); erd = e[36:32]; edata = e[31:0];
        if (acc) mq.push_back({i_lsu_rsp_rd, i_lsu_rsp_data});
      end else if (acc) begin
        erd = i_lsu_rsp_rd; edata = i_lsu_rsp_data;
      end else begin
        ev = 1'b0;
      end
      if (acc) sent++;
      step();
      n_tests++;
      if (o_rf_load !== ev || (ev && (o_rf_dest !== erd || o_rf_in !== edata))) begin
        n_fail++; $display("FAIL wrap_write cyc=%0d got %0b/%0d/%0h want %0b/%0d/%0h", cyc, o_rf_load, o_rf_dest, o_rf_in, ev, erd, edata);
      end
      if (o_rf_load && o_rf_dest >= 5'd8) seen++;
      cyc++;
    end
    idle();
    n_tests++; if (seen != 20) begin n_fail++; $display("FAIL wrap_count got %0d want 20", seen); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    i_lsu_issue = 1'b1; i_lsu_issue_rd = 5'd2;
    step();
    i_lsu_issue_rd = 5'd8;
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      i_alu_valid = 1'b1; i_alu_rd = 5'd1; i_alu_data = 32'(k);
      i_lsu_rsp_valid = 1'b1; i_lsu_rsp_rd = (k == 0) ? 5'd2 : (k == 1) ? 5'd8 : 5'd3;
      i_lsu_rsp_data = 32'hB0 + 32'(k);
      step();
    end
    idle();
    n_tests++; if (o_pending !== 32'h104) begin n_fail++; $display("FAIL mid_pending_pre got %0h want 104", o_pending); end
    n_tests++; if (o_rf_load !== 1'b1) begin n_fail++; $display("FAIL mid_load_pre got %0b want 1", o_rf_load); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (o_rf_load !== 1'b0) begin n_fail++; $display("FAIL mid_load got %0b want 0", o_rf_load); end
    n_tests++; if (o_pending !== 32'h0) begin n_fail++; $display("FAIL mid_pending got %0h want 0", o_pending); end
    n_tests++; if (o_lsu_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %0b want 1", o_lsu_rsp_ready); end
    step();
    #3 rst = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (o_rf_load !== 1'b0) begin n_fail++; $display("FAIL mid_nowrite k=%0d got %0b want 0", k, o_rf_load); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_alu_priority();
    test_x0();
    test_collision();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
